// File: rtl/pwm_peripheral_if.sv
// Control-byte and pin-drive bundle between the SPI register block (master)
// and the PWM peripheral (slave).
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin forced low, static high, or a shared 8-bit PWM
// waveform whose duty is double-buffered and reloaded only at a period boundary.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    counter;
  logic [7:0]    duty_shadow;
  logic [15:0]   out_q;
  logic          period_start_q;

  logic          tick;
  logic          boundary;
  logic          pwm_level;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   drive;

  assign tick      = (prescaler == PRE_LAST);
  assign boundary  = (prescaler == '0) && (counter == 8'd0);
  assign pwm_level = (duty_shadow == 8'hFF) || (counter < duty_shadow);

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Output enable dominates; enabled pins take the PWM level only in PWM mode.
  assign drive = en_out & (~en_pwm | {16{pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler      <= '0;
      counter        <= 8'd0;
      duty_shadow    <= 8'd0;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick)
        counter <= counter + 8'd1;
      // The output register samples pwm_level from the old shadow in this
      // same edge, so a new duty becomes visible one clk after period_start.
      if (boundary)
        duty_shadow <= bus.pwm_duty_cycle;
      period_start_q <= boundary;
      out_q          <= drive;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised scoreboard bench for pwm_peripheral at CLK_DIV = 13, 2 and 1,
// against a phase-arithmetic reference model.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] out;
    logic        ps;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          div_m[3] = '{13, 2, 1};
  int          k_m[3];
  logic [7:0]  shadow_m[3];

  pwm_peripheral_if if0 ();
  pwm_peripheral_if if1 ();
  pwm_peripheral_if if2 ();

  assign if0.en_reg_out_7_0  = en_out[7:0];
  assign if0.en_reg_out_15_8 = en_out[15:8];
  assign if0.en_reg_pwm_7_0  = en_pwm[7:0];
  assign if0.en_reg_pwm_15_8 = en_pwm[15:8];
  assign if0.pwm_duty_cycle  = duty;
  assign if1.en_reg_out_7_0  = en_out[7:0];
  assign if1.en_reg_out_15_8 = en_out[15:8];
  assign if1.en_reg_pwm_7_0  = en_pwm[7:0];
  assign if1.en_reg_pwm_15_8 = en_pwm[15:8];
  assign if1.pwm_duty_cycle  = duty;
  assign if2.en_reg_out_7_0  = en_out[7:0];
  assign if2.en_reg_out_15_8 = en_out[15:8];
  assign if2.en_reg_pwm_7_0  = en_pwm[7:0];
  assign if2.en_reg_pwm_15_8 = en_pwm[15:8];
  assign if2.pwm_duty_cycle  = duty;

  pwm_peripheral #(.CLK_DIV(13)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pwm_peripheral #(.CLK_DIV(2))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pwm_peripheral #(.CLK_DIV(1))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      k_m[i]      = 0;
      shadow_m[i] = 8'd0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Expected response of the upcoming posedge, from the edge index since reset
  // release: position within the period gives the counter value directly.
  task automatic push_all();
    for (int i = 0; i < 3; i++) begin
      int   per;
      int   p;
      int   cnt;
      logic lvl;
      exp_t e;
      per   = 256 * div_m[i];
      p     = k_m[i] % per;
      cnt   = p / div_m[i];
      lvl   = (shadow_m[i] == 8'hFF) || (cnt < int'(shadow_m[i]));
      e.out = en_out & (~en_pwm | {16{lvl}});
      e.ps  = (p == 0);
      if (p == 0) shadow_m[i] = duty;
      k_m[i] = k_m[i] + 1;
      case (i)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      push_all();
      @(negedge clk);
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_one(input int i, input logic [15:0] o, input logic ps);
    exp_t e;
    bit   has;
    has = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); has = 1'b1; end
    endcase
    if (has) begin
      cmp($sformatf("out_div%0d", div_m[i]), o, e.out);
      cmp($sformatf("period_start_div%0d", div_m[i]), {15'd0, ps}, {15'd0, e.ps});
    end else if (!rst_n) begin
      cmp($sformatf("rst_out_div%0d", div_m[i]), o, 16'h0000);
      cmp($sformatf("rst_period_start_div%0d", div_m[i]), {15'd0, ps}, 16'd0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_one(0, if0.out, if0.period_start);
    check_one(1, if1.out, if1.period_start);
    check_one(2, if2.out, if2.period_start);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    en_out = 16'h0000;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    reset_model();
    repeat (3) @(negedge clk);

    // static drive, then disable the upper byte
    en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h00; rst_n = 1'b1;
    run(20);
    en_out[15:8] = 8'h00;
    run(10);

    // 50% duty across two slow periods
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
    run(3328 * 2 + 50);

    // extremes
    duty = 8'h00; run(1100);
    duty = 8'hFF; run(1100);

    // shadowing: duty change mid-period
    duty = 8'h40; run(540);
    duty = 8'hC0; run(1100);

    // mixed modes, pin 0 has PWM mode without output enable
    en_out = 16'h00F0; en_pwm = 16'h0031; duty = 8'h40;
    run(1100);

    // asynchronous reset with the slow counter at 100, duty 0x80
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
    n = 0;
    while (n < 4000 && ((k_m[0] % 3328) / 13) != 100) begin
      run(1);
      n++;
    end
    cmp("reach_counter_100", 16'(((k_m[0] % 3328) / 13)), 16'd100);
    push_all();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_out", if0.out, 16'h0000);
    cmp("async_rst_period_start", {15'd0, if0.period_start}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    run(3328 + 20);

    // randomized control traffic
    for (int r = 0; r < 6000; r++) begin
      if ($urandom_range(0, 99) < 4) duty = 8'($urandom);
      if ($urandom_range(0, 99) < 2) en_out = 16'($urandom);
      if ($urandom_range(0, 99) < 2) en_pwm = 16'($urandom);
      if ($urandom_range(0, 999) < 3) duty = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      run(1);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
